// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: size codes, FSM states, alignment rule.
// Optional feature macro used by dm_arbiter: DM_ARBITER_FIXED_PRIO_EN.
package dm_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b11;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Codes other than byte/half are treated as word accesses.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~off[0];
            default: ok = (off == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dm_load_align.sv
// Combinational load extractor: picks the addressed byte/half out of a memory word
// and zero-extends it; word accesses pass straight through.
module dm_load_align
    import dm_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] dout,
    input  logic [1:0]        size,
    input  logic [1:0]        off,
    output logic [DATA_W-1:0] rdata
);

    always_comb begin
        rdata = '0;
        case (size)
            SZ_BYTE: rdata[7:0]  = dout[8*off +: 8];
            SZ_HALF: rdata[15:0] = dout[16*off[1] +: 16];
            default: rdata       = dout;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port scheduler in front of the single-port data memory (IDLE/ACCESS/RESP FSM).
// Define DM_ARBITER_FIXED_PRIO_EN to make port 0 win every tie instead of round-robin.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [1:0]        size0,
    input  logic [1:0]        size1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic [1:0]        mem_byte,
    input  logic [DATA_W-1:0] mem_dout
);

    state_t            state;
    logic              last;
    logic              lat_port;
    logic              lat_we;
    logic              lat_aligned;
    logic              pick;
    logic [DATA_W-1:0] load_data;

`ifdef DM_ARBITER_FIXED_PRIO_EN
    assign pick = req1 & ~req0;
`else
    // On a tie the port that did not win last time is served.
    assign pick = (req0 & req1) ? ~last : req1;
`endif

    // The latched request lives directly in the mem_* registers.
    assign lat_aligned = is_aligned(mem_byte, mem_addr[1:0]);
    assign mem_we      = (state == ST_ACCESS) & lat_we & lat_aligned;
    assign busy        = (state != ST_IDLE);

    dm_load_align #(.DATA_W(DATA_W)) u_load_align (
        .dout  (mem_dout),
        .size  (mem_byte),
        .off   (mem_addr[1:0]),
        .rdata (load_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            last     <= 1'b1;
            lat_port <= 1'b0;
            lat_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_byte <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (req0 | req1) begin
                        state    <= ST_ACCESS;
                        lat_port <= pick;
                        last     <= pick;
                        lat_we   <= pick ? we1 : we0;
                        mem_addr <= pick ? addr1 : addr0;
                        mem_din  <= pick ? wdata1 : wdata0;
                        mem_byte <= pick ? size1 : size0;
                        gnt0     <= ~pick;
                        gnt1     <= pick;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    state <= ST_RESP;
                    if (lat_aligned) begin
                        if (lat_port) done1 <= 1'b1;
                        else          done0 <= 1'b1;
                        if (!lat_we) begin
                            if (lat_port) rdata1 <= load_data;
                            else          rdata0 <= load_data;
                        end
                    end else begin
                        if (lat_port) err1 <= 1'b1;
                        else          err0 <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural data memory model.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req0, req1, we0, we1;
    logic [8:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  size0, size1;
    logic        gnt0, gnt1, done0, done1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        busy, mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_din, mem_dout;
    logic [1:0]  mem_byte;

    int n_checks = 0;
    int n_fail   = 0;

    int          gc, rc;
    bit          gd, ge, ws;
    logic [31:0] rd;

    always #5 clk = ~clk;

    dm_arbiter dut (
        .clk(clk), .rstn(rstn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .size0(size0), .size1(size1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_byte(mem_byte), .mem_dout(mem_dout)
    );

    // Data memory: synchronous write with byte/half lanes, combinational read.
    logic [31:0] mem [0:127];
    assign mem_dout = mem[mem_addr[8:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_byte)
                2'b11:   mem[mem_addr[8:2]][8*mem_addr[1:0] +: 8] <= mem_din[7:0];
                2'b10:   mem[mem_addr[8:2]][16*mem_addr[1] +: 16] <= mem_din[15:0];
                default: mem[mem_addr[8:2]] <= mem_din;
            endcase
        end
    end

    task automatic apply_reset();
        rstn = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; size0 = '0; size1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // One request on port p; reports grant/response cycle numbers relative to the request.
    task automatic access(input bit p, input logic w, input logic [8:0] a, input logic [31:0] d,
                          input logic [1:0] sz, output int g_cyc, output int r_cyc,
                          output bit got_done, output bit got_err, output bit we_seen,
                          output logic [31:0] rdv);
        g_cyc = -1; r_cyc = -1; got_done = 0; got_err = 0; we_seen = 0;
        @(negedge clk);
        if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; size1 = sz; end
        else   begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; size0 = sz; end
        for (int c = 1; c <= 8 && r_cyc < 0; c++) begin
            @(posedge clk); #1;
            if (mem_we) we_seen = 1;
            if ((p ? gnt1 : gnt0) && g_cyc < 0) begin
                g_cyc = c;
                if (p) req1 = 0; else req0 = 0;
            end
            if (p ? done1 : done0) begin got_done = 1; r_cyc = c; end
            if (p ? err1 : err0)   begin got_err = 1;  r_cyc = c; end
        end
        if (p) req1 = 0; else req0 = 0;
        rdv = p ? rdata1 : rdata0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; size0 = '0; size1 = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({gnt0, gnt1, done0, done1, err0, err1, busy, mem_we} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000000",
                     {gnt0, gnt1, done0, done1, err0, err1, busy, mem_we});
        end
        n_checks++;
        if ({rdata0, rdata1} !== 64'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h %h expected 0 0", rdata0, rdata1);
        end
        n_checks++;
        if ({mem_addr, mem_din, mem_byte} !== 43'h0) begin
            n_fail++; $display("FAIL reset_mem_bus: got %h %h %h expected 0", mem_addr, mem_din, mem_byte);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_store_load();
        access(0, 1, 9'h010, 32'hDEADBEEF, 2'b00, gc, rc, gd, ge, ws, rd);
        n_checks++;
        if (gc !== 1 || rc !== 2) begin
            n_fail++; $display("FAIL store_latency: got gnt=%0d done=%0d expected 1 2", gc, rc);
        end
        n_checks++;
        if (mem[4] !== 32'hDEADBEEF || gd !== 1'b1) begin
            n_fail++; $display("FAIL store_word: got mem=%h done=%0d expected deadbeef 1", mem[4], gd);
        end
        access(0, 0, 9'h010, 32'h0, 2'b00, gc, rc, gd, ge, ws, rd);
        n_checks++;
        if (rd !== 32'hDEADBEEF || gc !== 1 || rc !== 2) begin
            n_fail++; $display("FAIL load_word: got %h g=%0d r=%0d expected deadbeef 1 2", rd, gc, rc);
        end
    endtask

    task automatic test_sub_word();
        access(1, 1, 9'h020, 32'h11223344, 2'b00, gc, rc, gd, ge, ws, rd);
        access(1, 0, 9'h023, 32'h0, 2'b11, gc, rc, gd, ge, ws, rd);
        n_checks++;
        if (rd !== 32'h00000011) begin
            n_fail++; $display("FAIL byte_load: got %h expected 00000011", rd);
        end
        access(0, 1, 9'h022, 32'h0000ABCD, 2'b10, gc, rc, gd, ge, ws, rd);
        n_checks++;
        if (rd !== 32'hDEADBEEF || gd !== 1'b1) begin
            n_fail++; $display("FAIL store_keeps_rdata: got %h done=%0d expected deadbeef 1", rd, gd);
        end
        access(1, 0, 9'h020, 32'h0, 2'b00, gc, rc, gd, ge, ws, rd);
        n_checks++;
        if (rd !== 32'hABCD3344) begin
            n_fail++; $display("FAIL half_store: got %h expected abcd3344", rd);
        end
        access(0, 0, 9'h020, 32'h0, 2'b11, gc, rc, gd, ge, ws, rd);
        n_checks++;
        if (rd !== 32'h00000044) begin
            n_fail++; $display("FAIL byte_load_lane0: got %h expected 00000044", rd);
        end
        access(0, 0, 9'h022, 32'h0, 2'b10, gc, rc, gd, ge, ws, rd);
        n_checks++;
        if (rd !== 32'h0000ABCD) begin
            n_fail++; $display("FAIL half_load_upper: got %h expected 0000abcd", rd);
        end
    endtask

    task automatic test_misaligned();
        access(0, 1, 9'h021, 32'h55555555, 2'b00, gc, rc, gd, ge, ws, rd);
        n_checks++;
        if (ge !== 1'b1 || gd !== 1'b0 || rc !== 2) begin
            n_fail++; $display("FAIL misaligned_store_resp: got err=%0d done=%0d r=%0d expected 1 0 2", ge, gd, rc);
        end
        n_checks++;
        if (ws !== 1'b0 || mem[8] !== 32'hABCD3344) begin
            n_fail++; $display("FAIL misaligned_store_effect: got we=%0d mem=%h expected 0 abcd3344", ws, mem[8]);
        end
        access(1, 0, 9'h023, 32'h0, 2'b10, gc, rc, gd, ge, ws, rd);
        n_checks++;
        if (ge !== 1'b1 || gd !== 1'b0 || rd !== 32'hABCD3344) begin
            n_fail++; $display("FAIL misaligned_half_load: got err=%0d done=%0d rdata=%h expected 1 0 abcd3344", ge, gd, rd);
        end
    endtask

    task automatic test_req_during_access();
        @(negedge clk);
        req1 = 1; we1 = 0; addr1 = 9'h010; size1 = 2'b00;
        @(posedge clk); #1;
        n_checks++;
        if (gnt1 !== 1'b1) begin
            n_fail++; $display("FAIL late_req_gnt1: got %b expected 1", gnt1);
        end
        req1 = 0;
        req0 = 1; we0 = 0; addr0 = 9'h020; size0 = 2'b00;
        @(posedge clk); #1;
        n_checks++;
        if ({done1, gnt0} !== 2'b10) begin
            n_fail++; $display("FAIL late_req_ignored: got done1,gnt0=%b expected 10", {done1, gnt0});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({done1, gnt0} !== 2'b01) begin
            n_fail++; $display("FAIL late_req_granted: got done1,gnt0=%b expected 01", {done1, gnt0});
        end
        req0 = 0;
        @(posedge clk); #1;
        n_checks++;
        if (done0 !== 1'b1 || rdata0 !== 32'hABCD3344 || rdata1 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL late_req_data: got done0=%0d r0=%h r1=%h expected 1 abcd3344 deadbeef",
                               done0, rdata0, rdata1);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_round_robin();
        int order [4];
        int gcyc  [4];
        int exp_order [4];
        int n;
`ifdef DM_ARBITER_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        n = 0;
        for (int i = 0; i < 4; i++) begin order[i] = -1; gcyc[i] = -1; end
        apply_reset();
        req0 = 1; we0 = 0; addr0 = 9'h010; size0 = 2'b00;
        req1 = 1; we1 = 0; addr1 = 9'h020; size1 = 2'b00;
        for (int c = 1; c <= 20 && n < 4; c++) begin
            @(posedge clk); #1;
            if (gnt0 || gnt1) begin
                order[n] = gnt1 ? 1 : 0;
                gcyc[n]  = c;
                n++;
            end
        end
        req0 = 0; req1 = 0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (order[i] !== exp_order[i]) begin
                n_fail++; $display("FAIL grant_order[%0d]: got port %0d expected port %0d", i, order[i], exp_order[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (gcyc[i] - gcyc[i-1] !== 2) begin
                n_fail++; $display("FAIL grant_spacing[%0d]: got %0d cycles expected 2", i, gcyc[i] - gcyc[i-1]);
            end
        end
    endtask

    task automatic test_reset_abort();
        bit resp_seen;
        resp_seen = 0;
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 9'h030; wdata0 = 32'hCAFEF00D; size0 = 2'b00;
        @(posedge clk); #1;
        n_checks++;
        if ({gnt0, mem_we} !== 2'b11) begin
            n_fail++; $display("FAIL abort_setup: got gnt0,mem_we=%b expected 11", {gnt0, mem_we});
        end
        @(negedge clk);
        rstn = 1'b0;
        req0 = 0;
        #1;
        n_checks++;
        if ({mem_we, gnt0, busy} !== 3'b000) begin
            n_fail++; $display("FAIL abort_immediate: got mem_we,gnt0,busy=%b expected 000", {mem_we, gnt0, busy});
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done0 || err0) resp_seen = 1;
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            if (done0 || err0) resp_seen = 1;
        end
        n_checks++;
        if (resp_seen !== 1'b0 || mem[12] !== 32'h0) begin
            n_fail++; $display("FAIL abort_no_effect: got resp=%0d mem=%h expected 0 00000000", resp_seen, mem[12]);
        end
        n_checks++;
        if ({gnt0, gnt1, done0, done1, err0, err1, busy, mem_we} !== 8'h00 || {rdata0, rdata1} !== 64'h0) begin
            n_fail++; $display("FAIL abort_idle: got flags=%b r0=%h r1=%h expected 0",
                               {gnt0, gnt1, done0, done1, err0, err1, busy, mem_we}, rdata0, rdata1);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        test_reset();
        test_store_load();
        test_sub_word();
        test_misaligned();
        test_req_during_access();
        test_round_robin();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
